// File: rtl/piso_frame_tx.sv
// Parallel-in/serial-out frame transmitter.
// Captures DEPTH signed words on a load strobe and streams them out oldest-first
// (index DEPTH-1 first, index 0 last) over a valid/ready handshake.
// Optional: define PISO_FRAME_TX_B2B_EN to accept a new load on the final-beat
// edge, giving gapless back-to-back frames.

module piso_frame_tx #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int CNT_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [DEPTH*DATA_W-1:0]  d_in,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] d_out,
    output logic                     d_valid,
    output logic                     last,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [DATA_W-1:0] r_dout;
    logic                     r_valid;
    logic                     r_last;
    logic                     r_busy;
    logic                     r_done;
    logic [DATA_W-1:0]        r_mem [DEPTH];

    state_e                   w_state_nxt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic [CNT_W-1:0]         w_cnt_dec;
    logic signed [DATA_W-1:0] w_dout_nxt;
    logic                     w_valid_nxt;
    logic                     w_last_nxt;
    logic                     w_busy_nxt;
    logic                     w_done_nxt;
    logic                     w_capture;
    logic                     w_xfer;
    logic [DATA_W-1:0]        w_top_word;

    assign w_xfer     = r_valid && out_ready;
    assign w_cnt_dec  = r_cnt - CNT_W'(1);
    assign w_top_word = d_in[(DEPTH-1)*DATA_W +: DATA_W];

    // Next-state and next-output decode; everything defaults to hold.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dout_nxt  = r_dout;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_capture   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (load) begin
                    // First word is presented straight from d_in so it is
                    // visible one cycle after the load edge.
                    w_capture   = 1'b1;
                    w_state_nxt = StShift;
                    w_cnt_nxt   = CNT_W'(DEPTH - 1);
                    w_dout_nxt  = w_top_word;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_last_nxt  = 1'b0;
                end
            end
            StShift: begin
                if (w_xfer) begin
                    if (r_cnt == '0) begin
                        w_done_nxt  = 1'b1;
`ifdef PISO_FRAME_TX_B2B_EN
                        if (load) begin
                            w_capture   = 1'b1;
                            w_cnt_nxt   = CNT_W'(DEPTH - 1);
                            w_dout_nxt  = w_top_word;
                            w_valid_nxt = 1'b1;
                            w_busy_nxt  = 1'b1;
                            w_last_nxt  = 1'b0;
                        end else begin
                            w_state_nxt = StIdle;
                            w_valid_nxt = 1'b0;
                            w_busy_nxt  = 1'b0;
                            w_last_nxt  = 1'b0;
                        end
`else
                        w_state_nxt = StIdle;
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_last_nxt  = 1'b0;
`endif
                    end else begin
                        w_cnt_nxt  = w_cnt_dec;
                        w_dout_nxt = r_mem[w_cnt_dec];
                        w_last_nxt = (w_cnt_dec == '0);
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dout  <= w_dout_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Frame storage; contents are irrelevant until a load captures them.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= d_in[k*DATA_W +: DATA_W];
            end
        end
    end

    assign d_out   = r_dout;
    assign d_valid = r_valid;
    assign last    = r_last;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
